// File: rtl/riscv_opcodes_pkg.sv
// Shared register-file types and write-back constants.
package riscv_opcodes_pkg;

    typedef logic [4:0] rsd_t;

    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_EX   = 2'd1,
        WB_LD   = 2'd2
    } wb_src_e;

    localparam int LD_MAX_DEF = 2;

endpackage

// File: rtl/rf_wb_fifo.sv
// Load-return buffer: {rd, data} entries, head visible combinationally.
module rf_wb_fifo
    import riscv_opcodes_pkg::*;
#(
    parameter int DEPTH = LD_MAX_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  rsd_t                     i_push_rd,
    input  logic [31:0]              i_push_d,
    input  logic                     i_pop,
    output rsd_t                     o_head_rd,
    output logic [31:0]              o_head_d,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    rsd_t          r_rd_mem [DEPTH];
    logic [31:0]   r_d_mem  [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push_ok;
    logic          w_pop_ok;

    // A push into a full buffer is dropped; a pop of an empty one is ignored.
    assign w_push_ok = i_push & ~o_full;
    assign w_pop_ok  = i_pop & ~o_empty;

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_rd_mem[r_wr_ptr] <= i_push_rd;
            r_d_mem[r_wr_ptr]  <= i_push_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head_rd = r_rd_mem[r_rd_ptr];
    assign o_head_d  = r_d_mem[r_rd_ptr];
    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port controller: EX/load arbitration, load buffer,
// and pending-load scoreboard that stalls ID on hazards.
module rf_wb_arbiter
    import riscv_opcodes_pkg::*;
#(
    parameter int LD_MAX = LD_MAX_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_we_i,
    input  rsd_t        ex_dst_i,
    input  logic [31:0] ex_d_i,
    output logic        ex_wb_stall_o,
    input  logic        ld_issue_i,
    input  rsd_t        ld_rd_i,
    input  logic        ld_ack_i,
    input  rsd_t        ld_ack_rd_i,
    input  logic [31:0] ld_ack_d_i,
    output logic        ld_ready_o,
    input  rsd_t        id_rs1_i,
    input  rsd_t        id_rs2_i,
    input  rsd_t        id_rd_i,
    output logic        id_hazard_o,
    output logic        ld_full_o,
    output rsd_t        rf_dst_o,
    output logic [31:0] rf_dst_d_o,
    output logic        rf_we_o
);
    localparam int CW = $clog2(LD_MAX) + 1;

    logic          w_push;
    logic          w_pop;
    logic          w_fifo_full;
    logic          w_fifo_empty;
    logic [CW-1:0] w_fifo_cnt;
    rsd_t          w_head_rd;
    logic [31:0]   w_head_d;
    logic          w_ld_pri;
    wb_src_e       w_src;
    logic [31:0]   w_pending_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic [31:0]   r_pending;
    logic [CW-1:0] r_cnt;

    assign ld_ready_o = ~w_fifo_full;
    assign w_push     = ld_ack_i & ld_ready_o;

    rf_wb_fifo #(.DEPTH(LD_MAX)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_push    (w_push),
        .i_push_rd (ld_ack_rd_i),
        .i_push_d  (ld_ack_d_i),
        .i_pop     (w_pop),
        .o_head_rd (w_head_rd),
        .o_head_d  (w_head_d),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty),
        .o_count   (w_fifo_cnt)
    );

    // A full buffer flips priority to loads so returns can never be lost.
    assign w_ld_pri = (w_fifo_cnt == CW'(LD_MAX));

    // No grant while reset is asserted, so buffered loads are discarded unwritten.
    always_comb begin
        w_src = WB_NONE;
        if (rst_n) begin
            if (w_ld_pri)           w_src = WB_LD;
            else if (ex_we_i)       w_src = WB_EX;
            else if (!w_fifo_empty) w_src = WB_LD;
        end
    end

    always_comb begin
        rf_dst_o   = '0;
        rf_dst_d_o = '0;
        case (w_src)
            WB_EX: begin
                rf_dst_o   = ex_dst_i;
                rf_dst_d_o = ex_d_i;
            end
            WB_LD: begin
                rf_dst_o   = w_head_rd;
                rf_dst_d_o = w_head_d;
            end
            default: ;
        endcase
    end

    assign w_pop         = (w_src == WB_LD);
    assign rf_we_o       = (w_src != WB_NONE) && (rf_dst_o != '0);
    assign ex_wb_stall_o = rst_n & w_ld_pri & ex_we_i;

    // Set is applied after clear so an issue to the same register wins.
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_pop) w_pending_nxt[w_head_rd] = 1'b0;
        if (ld_issue_i && (ld_rd_i != '0)) w_pending_nxt[ld_rd_i] = 1'b1;
    end

    always_comb begin
        case ({ld_issue_i, w_pop})
            2'b10:   w_cnt_nxt = r_cnt + CW'(1);
            2'b01:   w_cnt_nxt = r_cnt - CW'(1);
            default: w_cnt_nxt = r_cnt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pending <= '0;
            r_cnt     <= '0;
        end else begin
            r_pending <= w_pending_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

    assign ld_full_o   = (r_cnt == CW'(LD_MAX));
    assign id_hazard_o = r_pending[id_rs1_i] | r_pending[id_rs2_i] |
                         r_pending[id_rd_i] | (ld_full_o & ld_issue_i);

    a_no_ack_when_full: assert property (
        @(posedge clk) disable iff (!rst_n) !(ld_ack_i && !ld_ready_o));

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-port controller for the 32×32 integer register file. It shares the single register-file write port between the in-order EX writeback and out-of-order load returns, buffering loads in a small FIFO. It also keeps a pending-load scoreboard that stalls ID on RAW/WAW hazards against outstanding loads. It sits between the EX/MEM stages and the register file, and drives the existing `rf_dst_i`/`rf_dst_d_i`/`rf_we_i` inputs.

## Interface
- `LD_MAX`, default 2: maximum outstanding loads; this is also the load FIFO depth (power of two, ≥2).
- `clk  in  1`: sole clock; all state updates on the rising edge.
- `rst_n  in  1`: reset, synchronous, active-low.
- `ex_we_i  in  1`: EX writeback valid this cycle.
- `ex_dst_i  in  rsd_t`: EX destination register.
- `ex_d_i  in  32`: EX writeback data.
- `ex_wb_stall_o  out  1`: EX write not granted this cycle; EX must hold `ex_*` stable.
- `ld_issue_i  in  1`: a load leaves ID this cycle (already qualified by `~id_stall`).
- `ld_rd_i  in  rsd_t`: destination of the issuing load.
- `ld_ack_i  in  1`: load data returns this cycle.
- `ld_ack_rd_i  in  rsd_t`: destination of the returned load.
- `ld_ack_d_i  in  32`: returned load data.
- `ld_ready_o  out  1`: FIFO can accept a return (not full).
- `id_rs1_i`, `id_rs2_i`, `id_rd_i  in  rsd_t`: operand and destination registers of the instruction in ID.
- `id_hazard_o  out  1`: ID must stall.
- `ld_full_o  out  1`: outstanding-load count equals `LD_MAX`.
- `rf_dst_o  out  rsd_t`: write port address.
- `rf_dst_d_o  out  32`: write port data.
- `rf_we_o  out  1`: write port enable.

## Operation
- **Scoreboard:** `pending[31:0]`.
  - `ld_issue_i` sets `pending[ld_rd_i]`; a load write granted to the port clears `pending[rf_dst_o]`.
  - Bit 0 is never set and always reads 0.
  - If set and clear hit the same register in one cycle, set wins.
- **Outstanding counter `cnt`:** +1 on `ld_issue_i`, −1 on a granted load write, both together → unchanged. `ld_full_o = (cnt == LD_MAX)`.
- **Hazard:** `id_hazard_o = pending[id_rs1_i] | pending[id_rs2_i] | pending[id_rd_i] | (ld_full_o & ld_issue_i)`. This prevents WAW, so EX and a load never target the same register while that load is pending.
- **Load FIFO:** depth `LD_MAX`, entries are {rd, data}.
  - Push when `ld_ack_i & ld_ready_o`; `ld_ack_i` while full is a protocol error (assertion, entry dropped).
  - A return whose `ld_ack_rd_i == 0` is pushed normally; it produces no write and no scoreboard clear.
- **Arbitration** (combinational, per cycle):
  - Mode EX_PRI (FIFO not full): EX wins if `ex_we_i`, otherwise the FIFO head wins if the FIFO is non-empty.
  - Mode LD_PRI (FIFO full): the FIFO head wins and `ex_wb_stall_o = ex_we_i`.
  - The mode is derived from the registered FIFO count; there is no separate state register.
- **Grant output:** `rf_dst_o` / `rf_dst_d_o` come from the winner. `rf_we_o = 1` iff there is a winner and its dst ≠ 0. An x0 winner still pops and still counts as granted.
- **Decrement rule:** `cnt` decrements on every FIFO pop, including x0 pops.

## Timing
- Reset (`rst_n = 0` at an edge): FIFO empty, `pending = 0`, `cnt = 0`. After reset, all outputs are 0 except `ld_ready_o = 1`.
- Reset mid-operation discards buffered loads and pending bits with no write.
- EX write reaches `rf` at the edge ending the grant cycle (zero added latency).
- Load return: pushed at edge N; earliest write cycle N+1; `rf` updated at the end of N+1. `pending` clears at the same edge, so `id_hazard_o` falls in cycle N+2.
- Simultaneous push and pop on a full FIFO is not allowed (`ld_ready_o = 0`). Push and pop on a non-full FIFO happen together with the count unchanged.
- Pointers wrap modulo `LD_MAX`.

## Structure
- `rsd_t` stays in `riscv_opcodes_pkg`.
- Add `wb_src_e` {WB_NONE, WB_EX, WB_LD} and the `LD_MAX_DEF = 2` constant to the same package.
- One sub-module: `rf_wb_fifo` (parameterised depth; push/pop/full/empty/count, head outputs).
- Arbiter, scoreboard and counter live in the top level.

## Test plan
- **Reset:** `rst_n = 0` for 2 cycles with `ex_we_i = 1`, `ex_dst_i = 5` → `rf_we_o = 0`, `id_hazard_o = 0`, `ld_ready_o = 1`; `ld_full_o = 0` after release.
- **Load hazard:** issue load rd = 7, `ld_ack` of x7 = 0xDEADBEEF two cycles later, with ID showing rs1 = 7 throughout → `id_hazard_o = 1` until the cycle after `rf_we_o = 1`, `rf_dst_o = 7`, `rf_dst_d_o = 0xDEADBEEF`.
- **Port contention:** EX write x3 = 0x11 in the same cycle a load return for x4 is pushed, then EX writes x5 back-to-back → x3 then x5 are written first. x4 is written on the first EX-idle cycle, or earlier if the FIFO fills.
- **FIFO full priority:** two load returns (x8, x9) while EX writes continuously → once the count reaches 2, `ex_wb_stall_o = 1`, x8 is written, and EX resumes the next cycle. `ld_ready_o = 0` only while the FIFO is full.
- **x0 handling:** issue load rd = 0 → no hazard on rs1 = 0. Its return pops with `rf_we_o = 0`, and `cnt` returns to 0.
- **Limit:** with `LD_MAX = 2`, issue 2 loads, then present a third `ld_issue_i` → `ld_full_o = 1`, `id_hazard_o = 1`; `ld_full_o` clears at the edge of the first load's write grant.
